lut_arbiter: RTL
================

// Module: lut_arbiter
// PURPOSE
//  Shares one colour-LUT read port among NUM_ENGINES Mandelbrot engines. Each engine offers
//  (iteration count, pixel address); a round-robin arbiter grants one request per cycle.
//  The iteration count is clamped and looked up in a synchronous-read ROM. The result is
//  presented as one RGB pixel stream toward the frame-buffer writer, with backpressure.
//  Also counts delivered pixels and pulses frame_done at the end of each frame.
// PARAMETERS
//  DATA_WIDTH       32      width of iteration count from each engine
//  RGB_SIZE         24      width of RGB value
//  ADDR_WIDTH       19      pixel address width (640x480 fits)
//  MAX_ITERATION    50      LUT depth; counts >= this map to IN_SET_RGB
//  NUM_ENGINES      6       number of requesters
//  PIXELS_PER_FRAME 307200  output pixels per frame
//  IN_SET_RGB       24'h0   colour for points that never escaped
// PORTS
//  clk          in   1                       clock
//  rst_n        in   1                       asynchronous active-low reset
//  req_valid    in   NUM_ENGINES             engine i has a result
//  req_iter     in   [DATA_WIDTH-1:0] x N    iteration count per engine
//  req_addr     in   [ADDR_WIDTH-1:0] x N    pixel address per engine
//  req_ready    out  NUM_ENGINES             one-hot grant; handshake when valid & ready
//  out_valid    out  1                       pixel available
//  out_ready    in   1                       downstream accepts pixel
//  out_rgb      out  RGB_SIZE                looked-up colour
//  out_addr     out  ADDR_WIDTH              pixel address of out_rgb
//  out_engine   out  $clog2(NUM_ENGINES)     engine index that produced the pixel
//  frame_done   out  1                       one-cycle pulse on the last pixel of a frame
// BEHAVIOUR
//  - Reset is asynchronous, active-low. All outputs reset to 0: req_ready, out_valid, out_rgb,
//    out_addr, out_engine, frame_done. The RR pointer resets to NUM_ENGINES-1, so engine 0
//    has first priority. The pixel counter resets to 0.
//  - Pipeline advance: adv = !out_valid || out_ready. When adv=0, req_ready=0 and the
//    output registers hold their values.
//  - Arbitration (combinational): if adv=1, grant the first valid engine searching
//    ptr+1, ptr+2, ... with mod-NUM_ENGINES wrap. req_ready is one-hot or zero and never
//    depends on req_ready itself. ptr <= granted index only on a handshake.
//  - Lookup: idx = (iter >= MAX_ITERATION) ? 0 : iter. A flag marks the clamped case.
//    The ROM is read synchronously with enable=adv.
//  - out_rgb = flag ? IN_SET_RGB : rom_q. Comparison is full DATA_WIDTH unsigned, with no
//    truncation before the compare.
//  - Latency: a handshake at edge E gives out_valid=1 in the cycle after E. Throughput is
//    1 pixel/clk while out_ready=1.
//  - out_valid: set on an edge with handshake. Cleared on an edge with out_valid & out_ready
//    and no new handshake. Simultaneous drain and accept keeps it at 1 with new data.
//  - Pixel counter: increments on each output handshake (out_valid & out_ready). On the
//    handshake where count == PIXELS_PER_FRAME-1: frame_done=1 in the next cycle and the
//    counter wraps to 0.
//  - Fairness: with all engines valid continuously and out_ready=1, each engine is granted
//    exactly once per NUM_ENGINES cycles. No engine waits more than NUM_ENGINES-1 grants.
//  - Reset mid-operation: the in-flight pixel is discarded; engines must re-present.
//  - Engines must hold valid/iter/addr stable until ready; behaviour is undefined otherwise.
// STRUCTURE
//  - mandel_pkg: rgb_t, iter_t, addr_t typedefs; MAX_ITERATION, IN_SET_RGB constants;
//    function rr_pick(valid, ptr).
//  - Sub-module lut_rom: sync-read ROM, loaded with $readmemh("lut.hex"), ports clk, en,
//    addr, q.
//  - Top level: arbiter + pointer, output register set, frame counter.
// TESTING
//  1. Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; after release,
//     engine 0 is granted first.
//  2. Single engine 3 with iter=7, addr=100 -> out_valid next cycle, out_rgb=lut[7],
//     out_addr=100, out_engine=3.
//  3. All 6 engines valid, out_ready=1 for 12 cycles -> grants in order 0..5,0..5,
//     12 pixels out back-to-back.
//  4. iter=50 and iter=32'hFFFF_FFFF -> out_rgb=IN_SET_RGB; iter=49 -> lut[49].
//  5. out_ready held 0 for 5 cycles while engines valid -> req_ready=0, outputs stable;
//     on release no pixel is lost or duplicated and the RR order resumes.
//  6. PIXELS_PER_FRAME=8, stream 20 pixels -> frame_done pulses after pixels 8 and 16.

Source files
------------

// File: rtl/lut_arbiter_pkg.sv
// Shared types, constants and helpers for the Mandelbrot colour-LUT arbiter.
// The palette function defines the ROM contents; rr_pick is the round-robin search.
package lut_arbiter_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [31:0] iter_t;
  typedef logic [18:0] addr_t;

  localparam int   MAX_ITERATION = 50;
  localparam rgb_t IN_SET_RGB    = 24'h000000;

  // Escape-time palette: red ramps up, green ramps down, blue wraps quickly.
  function automatic rgb_t lut_color(input logic [7:0] idx);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = idx * 8'd5;
    g = 8'hFF - r;
    b = idx * 8'd13;
    return {r, g, b};
  endfunction

  // Returns {found, index} of the first set valid bit after ptr, wrapping at n (n <= 16).
  function automatic logic [4:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr,
                                         input logic [4:0] n);
    logic [4:0] res;
    logic [4:0] c;
    logic [4:0] k;
    res = '0;
    for (k = 5'd1; k <= 5'd16; k = k + 5'd1) begin
      c = {1'b0, ptr} + k;
      if (c >= n) c = c - n;
      if (k <= n && !res[4] && valid[c[3:0]]) res = {1'b1, c[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/lut_arbiter_rom.sv
// Synchronous-read colour ROM, one entry per escape-time iteration count.
module lut_rom
  import lut_arbiter_pkg::*;
#(
  parameter int DEPTH    = MAX_ITERATION,
  parameter int IDX_W    = $clog2(MAX_ITERATION),
  parameter int RGB_SIZE = 24
) (
  input  logic                clk,
  input  logic                en,
  input  logic [IDX_W-1:0]    addr,
  output logic [RGB_SIZE-1:0] q
);

  logic [RGB_SIZE-1:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fill
    assign rom[gi] = RGB_SIZE'(lut_color(8'(gi)));
  end

  always_ff @(posedge clk) begin
    if (en) q <= rom[addr];
  end

endmodule

// File: rtl/lut_arbiter.sv
// Round-robin share of one colour-LUT port among several Mandelbrot engines,
// producing a backpressured RGB pixel stream with a per-frame done pulse.
module lut_arbiter
  import lut_arbiter_pkg::*;
#(
  parameter int                DATA_WIDTH       = 32,
  parameter int                RGB_SIZE         = 24,
  parameter int                ADDR_WIDTH       = 19,
  parameter int                MAX_ITERATION    = lut_arbiter_pkg::MAX_ITERATION,
  parameter int                NUM_ENGINES      = 6,
  parameter int                PIXELS_PER_FRAME = 307200,
  parameter logic [RGB_SIZE-1:0] IN_SET_RGB     = RGB_SIZE'(lut_arbiter_pkg::IN_SET_RGB),
  localparam int               ENG_W            = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_ENGINES-1:0]                  req_valid,
  input  logic [NUM_ENGINES-1:0][DATA_WIDTH-1:0]  req_iter,
  input  logic [NUM_ENGINES-1:0][ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_ENGINES-1:0]                  req_ready,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [RGB_SIZE-1:0]                     out_rgb,
  output logic [ADDR_WIDTH-1:0]                   out_addr,
  output logic [ENG_W-1:0]                        out_engine,
  output logic                                    frame_done
);

  localparam int IDX_W = $clog2(MAX_ITERATION);
  localparam int CNT_W = (PIXELS_PER_FRAME > 2) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS_PER_FRAME - 1);
  localparam logic [4:0]       N5       = 5'(NUM_ENGINES);

  logic [ENG_W-1:0]      ptr_reg;
  logic                  out_valid_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ENG_W-1:0]      engine_reg;
  logic                  flag_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  frame_done_reg;

  logic                   adv;
  logic [4:0]             pick;
  logic                   hs;
  logic [ENG_W-1:0]       gidx;
  logic [NUM_ENGINES-1:0] grant;
  logic [DATA_WIDTH-1:0]  sel_iter;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   clamp;
  logic [IDX_W-1:0]       rom_idx;
  logic [RGB_SIZE-1:0]    rom_q;

  // No grants while reset is held, so engines never see a phantom handshake.
  always_comb begin
    adv      = !out_valid_reg || out_ready;
    pick     = rr_pick(16'(req_valid), 4'(ptr_reg), N5);
    gidx     = ENG_W'(pick[3:0]);
    hs       = adv && pick[4] && rst_n;
    grant    = '0;
    if (hs) grant[gidx] = 1'b1;
    sel_iter = req_iter[gidx];
    sel_addr = req_addr[gidx];
    clamp    = sel_iter >= DATA_WIDTH'(MAX_ITERATION);
    rom_idx  = clamp ? '0 : sel_iter[IDX_W-1:0];
  end

  lut_rom #(
    .DEPTH   (MAX_ITERATION),
    .IDX_W   (IDX_W),
    .RGB_SIZE(RGB_SIZE)
  ) u_rom (
    .clk (clk),
    .en  (adv),
    .addr(rom_idx),
    .q   (rom_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= ENG_W'(NUM_ENGINES - 1);
      out_valid_reg  <= 1'b0;
      addr_reg       <= '0;
      engine_reg     <= '0;
      flag_reg       <= 1'b0;
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      if (hs) ptr_reg <= gidx;
      if (adv) begin
        out_valid_reg <= hs;
        if (hs) begin
          addr_reg   <= sel_addr;
          engine_reg <= gidx;
          flag_reg   <= clamp;
        end
      end
      frame_done_reg <= 1'b0;
      if (out_valid_reg && out_ready) begin
        if (cnt_reg == LAST_PIX) begin
          cnt_reg        <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign req_ready  = grant;
  assign out_valid  = out_valid_reg;
  // The ROM output register has no reset, so the colour is blanked while idle.
  assign out_rgb    = out_valid_reg ? (flag_reg ? IN_SET_RGB : rom_q) : '0;
  assign out_addr   = addr_reg;
  assign out_engine = engine_reg;
  assign frame_done = frame_done_reg;

endmodule
